// File: rtl/router_sched_pkg.sv
// Shared state encoding for the layer-level router sequencer.
package router_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_STREAM,
    S_NEXT,
    S_DONE
  } sched_state_e;
endpackage

// File: rtl/router_scheduler_loop_counter.sv
// Loop index with synchronous clear and step; o_last flags count == bound-1.
// Count updates one cycle after clear/step; no backpressure.
module loop_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_bound,
  output logic [WIDTH-1:0] o_count,
  output logic             o_last
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear)     count_d = '0;
    else if (i_step) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_count = count_q;
  assign o_last  = (count_q == i_bound - WIDTH'(1));
endmodule

// File: rtl/router_scheduler.sv
// Sequences input/weight routers over tiles x contexts; start->reg_clear +1, en +2.
// Pops follow i_pe_ready combinationally; each router stops popping after its context-done.
module router_scheduler
  import router_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CNT_WIDTH-1:0]  i_tile_count,
  input  logic [CNT_WIDTH-1:0]  i_ctx_count,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_tile_stride,
  input  logic [ADDR_WIDTH-1:0] i_ctx_stride,
  input  logic                  i_pe_ready,
  input  logic                  i_ir_ready,
  input  logic                  i_ir_context_done,
  input  logic                  i_wr_ready,
  input  logic                  i_wr_context_done,
  output logic                  o_ir_en,
  output logic                  o_ir_reg_clear,
  output logic                  o_ir_pop_en,
  output logic                  o_wr_en,
  output logic                  o_wr_reg_clear,
  output logic                  o_wr_pop_en,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic [CNT_WIDTH-1:0]  o_tile_idx,
  output logic [CNT_WIDTH-1:0]  o_ctx_idx,
  output logic                  o_acc_clear,
  output logic                  o_acc_commit,
  output logic                  o_busy,
  output logic                  o_done
);
  sched_state_e state_q, state_d;
  logic abort_q, abort_d, acc_clear_q, acc_clear_d;
  logic ir_rdy_q, ir_rdy_d, wr_rdy_q, wr_rdy_d;
  logic ir_cd_q, ir_cd_d, wr_cd_q, wr_cd_d;
  logic [CNT_WIDTH-1:0]  tile_cnt_q, tile_cnt_d, ctx_cnt_q, ctx_cnt_d;
  logic [ADDR_WIDTH-1:0] tile_stride_q, tile_stride_d, ctx_stride_q, ctx_stride_d;
  logic [ADDR_WIDTH-1:0] tile_addr_q, tile_addr_d, start_addr_q, start_addr_d;
  logic tile_clr, tile_step, tile_last, ctx_clr, ctx_step, ctx_last;
  logic ir_rdy_now, wr_rdy_now, ir_cd_now, wr_cd_now;

  assign ir_rdy_now = ir_rdy_q | i_ir_ready;
  assign wr_rdy_now = wr_rdy_q | i_wr_ready;
  assign ir_cd_now  = ir_cd_q | i_ir_context_done;
  assign wr_cd_now  = wr_cd_q | i_wr_context_done;

  always_comb begin
    state_d       = state_q;
    abort_d       = 1'b0;
    acc_clear_d   = 1'b0;
    ir_rdy_d      = ir_rdy_q;
    wr_rdy_d      = wr_rdy_q;
    ir_cd_d       = ir_cd_q;
    wr_cd_d       = wr_cd_q;
    tile_cnt_d    = tile_cnt_q;
    ctx_cnt_d     = ctx_cnt_q;
    tile_stride_d = tile_stride_q;
    ctx_stride_d  = ctx_stride_q;
    tile_addr_d   = tile_addr_q;
    start_addr_d  = start_addr_q;
    tile_clr      = 1'b0;
    tile_step     = 1'b0;
    ctx_clr       = 1'b0;
    ctx_step      = 1'b0;
    if (i_abort && state_q != S_IDLE) begin
      abort_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_start && !i_abort) begin
          tile_cnt_d    = i_tile_count;
          ctx_cnt_d     = i_ctx_count;
          tile_stride_d = i_tile_stride;
          ctx_stride_d  = i_ctx_stride;
          tile_addr_d   = i_base_addr;
          start_addr_d  = i_base_addr;
          tile_clr      = 1'b1;
          ctx_clr       = 1'b1;
          state_d = (i_tile_count == '0 || i_ctx_count == '0) ? S_DONE : S_CLEAR;
        end
        S_CLEAR: begin
          ir_rdy_d = 1'b0;
          wr_rdy_d = 1'b0;
          ir_cd_d  = 1'b0;
          wr_cd_d  = 1'b0;
          state_d  = S_LOAD;
        end
        S_LOAD: begin
          ir_rdy_d = ir_rdy_now;
          wr_rdy_d = wr_rdy_now;
          // An early context-done is kept so STREAM can retire it immediately.
          ir_cd_d  = ir_cd_now;
          wr_cd_d  = wr_cd_now;
          if (ir_rdy_now && wr_rdy_now) begin
            state_d     = S_STREAM;
            acc_clear_d = (o_ctx_idx == '0);
          end
        end
        S_STREAM: begin
          ir_cd_d = ir_cd_now;
          wr_cd_d = wr_cd_now;
          if (ir_cd_now && wr_cd_now) state_d = S_NEXT;
        end
        S_NEXT: begin
          if (!ctx_last) begin
            ctx_step     = 1'b1;
            start_addr_d = start_addr_q + ctx_stride_q;
            state_d      = S_CLEAR;
          end else if (!tile_last) begin
            tile_step    = 1'b1;
            ctx_clr      = 1'b1;
            tile_addr_d  = tile_addr_q + tile_stride_q;
            start_addr_d = tile_addr_q + tile_stride_q;
            state_d      = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q       <= S_IDLE;
      abort_q       <= 1'b0;
      acc_clear_q   <= 1'b0;
      ir_rdy_q      <= 1'b0;
      wr_rdy_q      <= 1'b0;
      ir_cd_q       <= 1'b0;
      wr_cd_q       <= 1'b0;
      tile_cnt_q    <= '0;
      ctx_cnt_q     <= '0;
      tile_stride_q <= '0;
      ctx_stride_q  <= '0;
      tile_addr_q   <= '0;
      start_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      acc_clear_q   <= acc_clear_d;
      ir_rdy_q      <= ir_rdy_d;
      wr_rdy_q      <= wr_rdy_d;
      ir_cd_q       <= ir_cd_d;
      wr_cd_q       <= wr_cd_d;
      tile_cnt_q    <= tile_cnt_d;
      ctx_cnt_q     <= ctx_cnt_d;
      tile_stride_q <= tile_stride_d;
      ctx_stride_q  <= ctx_stride_d;
      tile_addr_q   <= tile_addr_d;
      start_addr_q  <= start_addr_d;
    end
  end

  loop_counter #(.WIDTH(CNT_WIDTH)) u_tile_ctr (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_clear(tile_clr), .i_step(tile_step),
    .i_bound(tile_cnt_q), .o_count(o_tile_idx), .o_last(tile_last)
  );

  loop_counter #(.WIDTH(CNT_WIDTH)) u_ctx_ctr (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_clear(ctx_clr), .i_step(ctx_step),
    .i_bound(ctx_cnt_q), .o_count(o_ctx_idx), .o_last(ctx_last)
  );

  assign o_ir_en        = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign o_wr_en        = o_ir_en;
  assign o_ir_reg_clear = (state_q == S_CLEAR) || abort_q;
  assign o_wr_reg_clear = o_ir_reg_clear;
  assign o_ir_pop_en    = (state_q == S_STREAM) && i_pe_ready && !ir_cd_q;
  assign o_wr_pop_en    = (state_q == S_STREAM) && i_pe_ready && !wr_cd_q;
  assign o_start_addr   = start_addr_q;
  assign o_acc_clear    = acc_clear_q;
  assign o_acc_commit   = (state_q == S_NEXT) && ctx_last;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
endmodule

// File: tb/tb_router_scheduler.sv
// Directed and randomized layer runs checked against a loop/address model of the scheduler.
module tb_router_scheduler;
  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       i_start, i_abort, i_pe_ready;
  logic [7:0] i_tile_count, i_ctx_count, i_base_addr, i_tile_stride, i_ctx_stride;
  logic       i_ir_ready, i_ir_context_done, i_wr_ready, i_wr_context_done;
  logic       o_ir_en, o_ir_reg_clear, o_ir_pop_en, o_wr_en, o_wr_reg_clear, o_wr_pop_en;
  logic [7:0] o_start_addr, o_tile_idx, o_ctx_idx;
  logic       o_acc_clear, o_acc_commit, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  router_scheduler #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
    .i_tile_count(i_tile_count), .i_ctx_count(i_ctx_count), .i_base_addr(i_base_addr),
    .i_tile_stride(i_tile_stride), .i_ctx_stride(i_ctx_stride), .i_pe_ready(i_pe_ready),
    .i_ir_ready(i_ir_ready), .i_ir_context_done(i_ir_context_done),
    .i_wr_ready(i_wr_ready), .i_wr_context_done(i_wr_context_done),
    .o_ir_en(o_ir_en), .o_ir_reg_clear(o_ir_reg_clear), .o_ir_pop_en(o_ir_pop_en),
    .o_wr_en(o_wr_en), .o_wr_reg_clear(o_wr_reg_clear), .o_wr_pop_en(o_wr_pop_en),
    .o_start_addr(o_start_addr), .o_tile_idx(o_tile_idx), .o_ctx_idx(o_ctx_idx),
    .o_acc_clear(o_acc_clear), .o_acc_commit(o_acc_commit), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    i_start = 1'b0; i_abort = 1'b0;
    i_ir_ready = 1'b0; i_wr_ready = 1'b0;
    i_ir_context_done = 1'b0; i_wr_context_done = 1'b0;
  endtask

  // Negative latency/done arguments pick a random value.
  // pe_mode: 0 random, 1 alternating 1010, 2 always ready.
  task automatic run_layer(input int tiles, input int ctxs, input logic [7:0] base,
                           input logic [7:0] ts, input logic [7:0] cs, input int pe_mode,
                           input int abort_ctx, input int k_ir, input int k_wr,
                           input int d_ir, input int d_wr);
    logic [7:0] exp_addr;
    int ki, kw, di, dw;
    logic pe;
    @(negedge i_clk);
    clear_pulses();
    i_tile_count = 8'(tiles); i_ctx_count = 8'(ctxs);
    i_base_addr = base; i_tile_stride = ts; i_ctx_stride = cs;
    i_start = 1'b1;
    @(negedge i_clk);
    clear_pulses();
    for (int t = 0; t < tiles; t++) begin
      for (int c = 0; c < ctxs; c++) begin
        exp_addr = base + 8'(t) * ts + 8'(c) * cs;
        chk("clear_ir", o_ir_reg_clear, 1);
        chk("clear_wr", o_wr_reg_clear, 1);
        chk("clear_en", o_ir_en | o_wr_en, 0);
        chk("start_addr", o_start_addr, exp_addr);
        chk("tile_idx", o_tile_idx, t);
        chk("ctx_idx", o_ctx_idx, c);
        ki = (k_ir < 0) ? int'($urandom_range(0, 3)) : k_ir;
        kw = (k_wr < 0) ? int'($urandom_range(0, 3)) : k_wr;
        di = (d_ir < 0) ? int'($urandom_range(0, 5)) : d_ir;
        dw = (d_wr < 0) ? int'($urandom_range(0, 5)) : d_wr;
        @(negedge i_clk);
        for (int k = 0; k <= ((ki > kw) ? ki : kw); k++) begin
          clear_pulses();
          i_ir_ready = (k == ki); i_wr_ready = (k == kw);
          i_pe_ready = 1'($urandom);
          #1;
          chk("load_en", {o_ir_en, o_wr_en}, 2'b11);
          chk("load_pop", {o_ir_pop_en, o_wr_pop_en}, 2'b00);
          chk("load_clear", o_ir_reg_clear, 0);
          @(negedge i_clk);
        end
        for (int s = 0; s <= ((di > dw) ? di : dw); s++) begin
          clear_pulses();
          pe = (pe_mode == 1) ? (s % 2 == 0) : (pe_mode == 2) ? 1'b1 : 1'($urandom);
          i_pe_ready = pe;
          if (t == 0 && c == abort_ctx && s == 1) begin
            i_abort = 1'b1;
            @(negedge i_clk);
            clear_pulses();
            i_pe_ready = 1'b1;
            #1;
            chk("abort_clear", {o_ir_reg_clear, o_wr_reg_clear}, 2'b11);
            chk("abort_en", {o_ir_en, o_wr_en, o_ir_pop_en, o_wr_pop_en}, 4'b0000);
            chk("abort_flags", {o_busy, o_done, o_acc_commit}, 3'b000);
            @(negedge i_clk);
            chk("abort_clear_end", {o_ir_reg_clear, o_busy}, 2'b00);
            return;
          end
          i_ir_context_done = (s == di); i_wr_context_done = (s == dw);
          i_start = 1'($urandom);
          #1;
          chk("stream_en", {o_ir_en, o_wr_en}, 2'b11);
          chk("acc_clear", o_acc_clear, (s == 0 && c == 0));
          chk("ir_pop", o_ir_pop_en, (pe && s <= di));
          chk("wr_pop", o_wr_pop_en, (pe && s <= dw));
          chk("stream_busy", o_busy, 1);
          @(negedge i_clk);
        end
        clear_pulses();
        i_pe_ready = 1'b1;
        #1;
        chk("next_en", {o_ir_en, o_wr_en, o_ir_pop_en, o_wr_pop_en}, 4'b0000);
        chk("acc_commit", o_acc_commit, (c == ctxs - 1));
        chk("next_acc_clear", o_acc_clear, 0);
        @(negedge i_clk);
      end
    end
    chk("done", o_done, 1);
    chk("done_busy", o_busy, 1);
    chk("done_clear", o_ir_reg_clear, 0);
    @(negedge i_clk);
    chk("idle_done", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    i_nrst = 1'b0;
    clear_pulses();
    i_pe_ready = 1'b0;
    i_tile_count = '0; i_ctx_count = '0;
    i_base_addr = '0; i_tile_stride = '0; i_ctx_stride = '0;
    #12;
    chk("rst_outputs", {o_ir_en, o_ir_reg_clear, o_ir_pop_en, o_wr_en, o_wr_reg_clear,
                        o_wr_pop_en, o_acc_clear, o_acc_commit, o_busy, o_done}, 0);
    chk("rst_addr", o_start_addr, 0);
    chk("rst_idx", {o_tile_idx, o_ctx_idx}, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    run_layer(1, 1, 8'h10, 8'h00, 8'h00, 2, -1, 3, 3, 4, 4);
    run_layer(2, 3, 8'h00, 8'h40, 8'h08, 0, -1, -1, -1, -1, -1);
    run_layer(1, 1, 8'h20, 8'h00, 8'h00, 0, -1, 0, 2, 1, 5);
    run_layer(1, 2, 8'h30, 8'h00, 8'h04, 1, -1, 1, 0, 3, 3);
    run_layer(1, 3, 8'h20, 8'h00, 8'h04, 2, 1, 1, 1, 4, 4);
    run_layer(1, 2, 8'h50, 8'h00, 8'h04, 0, -1, -1, -1, -1, -1);

    // Zero context count: straight to DONE with no router activity.
    @(negedge i_clk);
    i_tile_count = 8'd2; i_ctx_count = 8'd0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("zero_done", o_done, 1);
    chk("zero_router", {o_ir_en, o_wr_en, o_ir_reg_clear, o_wr_reg_clear}, 4'b0000);
    @(negedge i_clk);
    chk("zero_idle", {o_done, o_busy}, 2'b00);

    // Abort beats a simultaneous start in IDLE.
    i_tile_count = 8'd1; i_ctx_count = 8'd1; i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk);
    clear_pulses();
    chk("abort_start_idle", {o_busy, o_ir_reg_clear}, 2'b00);

    run_layer(1, 3, 8'hF8, 8'h00, 8'h10, 0, -1, -1, -1, -1, -1);
    for (int n = 0; n < 4; n++) begin
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 8'($urandom),
                8'($urandom), 8'($urandom), 0, -1, -1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
